z80_bus_master: RTL and testbench

//  Synthesizable Z80-style bus initiator. It drives MREQ/IORQ/RD/WR/A/D cycles into the z80bd

---
 rtl/z80_bus_master_if.sv | 30 +++
 rtl/z80_bus_master.sv | 185 ++++++++++++++++++
 tb/tb_z80_bus_master.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_master_if.sv
// Request handshake and Z80 bus strobe/address group for z80_bus_master.
// The bidirectional data bus D stays a plain inout port on the master itself.
interface z80_bus_master_if;
    logic        req;
    logic        we;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] A;
    logic        MREQ;
    logic        IORQ;
    logic        RD;
    logic        WR;
    logic        M1;
    logic        WAIT;

    modport master (
        input  req, we, io, addr, wdata, WAIT,
        output ready, done, err, rdata, A, MREQ, IORQ, RD, WR, M1
    );

    modport slave (
        output req, we, io, addr, wdata, WAIT,
        input  ready, done, err, rdata, A, MREQ, IORQ, RD, WR, M1
    );
endinterface

// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: turns single requests into MREQ/IORQ read/write cycles
// with T-state sequencing, WAIT stretching and a bounded wait-timeout abort.
module z80_bus_master #(
    parameter int TSTATE_CLKS = 2,
    parameter int MAX_WAIT    = 15
) (
    input  logic             CLK_24MHz,
    input  logic             RES,
    z80_bus_master_if.master bus,
    inout  wire  [7:0]       D
);
    localparam int                TICK_W     = (TSTATE_CLKS > 1) ? $clog2(TSTATE_CLKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TSTATE_CLKS - 1);
    localparam logic [7:0]        WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic              io_q, io_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              mreq_q, mreq_d;
    logic              iorq_q, iorq_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              d_oe_q, d_oe_d;
    logic              last_tick;
    logic              wait_sample;
    logic              strobe_phase;

    always_comb begin
        last_tick    = (tick_q == TICK_LAST);
        wait_sample  = 1'b0;
        strobe_phase = 1'b0;
        state_d      = state_q;
        tick_d       = tick_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        io_d         = io_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d    = S_T1;
                    we_d       = bus.we;
                    io_d       = bus.io;
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    wait_cnt_d = '0;
                end
            end
            S_T1: begin
                if (last_tick) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                // I/O cycles always get one TW that does not count toward the timeout
                if (last_tick) begin
                    if (io_q) begin
                        state_d = S_TW;
                    end else begin
                        wait_sample = 1'b1;
                    end
                end
            end
            S_TW: begin
                wait_sample = last_tick;
            end
            S_T3: begin
                if (last_tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = D;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wait_sample) begin
            if (bus.WAIT) begin
                state_d = S_T3;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                state_d    = S_TW;
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end

        if (state_q == S_IDLE) begin
            tick_d = '0;
        end else begin
            tick_d = last_tick ? '0 : tick_q + TICK_W'(1);
        end

        // Bus pins are computed from the next state so they come straight off flops
        strobe_phase = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
        mreq_d       = !(strobe_phase && !io_d);
        iorq_d       = !(strobe_phase && io_d);
        rd_d         = !(strobe_phase && !we_d);
        wr_d         = !(strobe_phase && we_d);
        d_oe_d       = we_d && (state_d != S_IDLE);
        ready_d      = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            mreq_q     <= 1'b1;
            iorq_q     <= 1'b1;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            d_oe_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            io_q       <= io_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            mreq_q     <= mreq_d;
            iorq_q     <= iorq_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            d_oe_q     <= d_oe_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.A     = addr_q;
    assign bus.MREQ  = mreq_q;
    assign bus.IORQ  = iorq_q;
    assign bus.RD    = rd_q;
    assign bus.WR    = wr_q;
    assign bus.M1    = 1'b1;
    assign D         = d_oe_q ? wdata_q : 8'hzz;

    a_req_exclusive: assert property (@(posedge CLK_24MHz) disable iff (!RES) mreq_q || iorq_q);
    a_dir_exclusive: assert property (@(posedge CLK_24MHz) disable iff (!RES) rd_q || wr_q);
    a_drive_only_writing: assert property (@(posedge CLK_24MHz) disable iff (!RES)
        d_oe_q |-> (we_q && state_q != S_IDLE));
endmodule

// File: tb/tb_z80_bus_master.sv
// Directed, table-driven bench for z80_bus_master with TSTATE_CLKS=2 and MAX_WAIT=15.
// Per-cycle timing expectations are hand-computed in T-state units of two clocks.
module tb_z80_bus_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       resp_oe;
    logic [7:0] resp_val;
    wire  [7:0] d_bus;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    z80_bus_master_if bif ();

    assign d_bus = resp_oe ? resp_val : 8'hzz;

    z80_bus_master #(
        .TSTATE_CLKS(2),
        .MAX_WAIT   (15)
    ) dut (
        .CLK_24MHz(clk),
        .RES      (rst_n),
        .bus      (bif.master),
        .D        (d_bus)
    );

    typedef struct {
        logic        we;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  resp;
        int          wait_lo;
        int          poke;
        int          exp_done;
        int          exp_strobe;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issues one request at the current time and follows it clock by clock until done.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int         first_sample;
        int         last_low;
        int         done_at;
        int         strobe_cnt;
        int         bad_other;
        int         bad_a;
        int         bad_d;
        int         bad_ready;
        logic       err_seen;
        logic       done_strobes;
        logic       done_ready;
        logic [15:0] done_a;
        logic [7:0] done_rdata;
        logic [7:0] d_probe;
        logic       prim;
        logic       dir;

        first_sample = v.io ? 5 : 3;
        last_low     = (v.wait_lo > 0) ? first_sample + 2 * v.wait_lo - 2 : -1;
        done_at      = -1;
        strobe_cnt   = 0;
        bad_other    = 0;
        bad_a        = 0;
        bad_d        = 0;
        bad_ready    = 0;
        err_seen     = 1'bx;
        done_strobes = 1'b0;
        done_ready   = 1'b0;
        done_a       = ~v.addr;
        done_rdata   = ~v.exp_rdata;
        d_probe      = 8'hxx;

        bif.we    = v.we;
        bif.io    = v.io;
        bif.addr  = v.addr;
        bif.wdata = v.wdata;
        bif.req   = 1'b1;
        bif.WAIT  = 1'b1;
        resp_oe   = !v.we;
        resp_val  = v.resp;

        for (int j = 0; j < 60 && done_at < 0; j++) begin
            @(negedge clk);
            if (j == 0) begin
                bif.req   = 1'b0;
                bif.we    = ~v.we;
                bif.io    = ~v.io;
                bif.addr  = ~v.addr;
                bif.wdata = ~v.wdata;
            end
            if (j == v.poke) begin
                bif.req  = 1'b1;
                bif.addr = 16'h9999;
            end else if (j == v.poke + 1) begin
                bif.req = 1'b0;
            end
            bif.WAIT = (j <= last_low) ? 1'b0 : 1'b1;

            if (bif.done === 1'b1) begin
                done_at      = j;
                err_seen     = bif.err;
                done_strobes = bif.MREQ & bif.IORQ & bif.RD & bif.WR & bif.M1;
                done_ready   = bif.ready;
                done_a       = bif.A;
                done_rdata   = bif.rdata;
                resp_oe      = 1'b1;
                resp_val     = 8'h00;
                #1;
                d_probe      = d_bus;
                resp_oe      = 1'b0;
            end else begin
                prim = v.io ? bif.IORQ : bif.MREQ;
                dir  = v.we ? bif.WR : bif.RD;
                if (prim === 1'b0 && dir === 1'b0) strobe_cnt++;
                if (prim !== dir) bad_other++;
                if (j < 2 && prim !== 1'b1) bad_other++;
                if ((v.io ? bif.MREQ : bif.IORQ) !== 1'b1) bad_other++;
                if ((v.we ? bif.RD : bif.WR) !== 1'b1) bad_other++;
                if (bif.M1 !== 1'b1) bad_other++;
                if (bif.A !== v.addr) bad_a++;
                if (v.we ? (d_bus !== v.wdata) : (d_bus !== v.resp)) bad_d++;
                if (bif.ready !== 1'b0) bad_ready++;
            end
        end

        check_output({tag, " done_clock"}, done_at, v.exp_done);
        check_output({tag, " err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
        check_output({tag, " strobe_clocks"}, strobe_cnt, v.exp_strobe);
        check_output({tag, " stray_strobes"}, bad_other, 0);
        check_output({tag, " addr_hold"}, bad_a, 0);
        check_output({tag, " data_bus"}, bad_d, 0);
        check_output({tag, " ready_busy"}, bad_ready, 0);
        check_output({tag, " strobes_at_done"}, {31'd0, done_strobes}, 32'd1);
        check_output({tag, " ready_at_done"}, {31'd0, done_ready}, 32'd1);
        check_output({tag, " addr_at_done"}, {16'd0, done_a}, {16'd0, v.addr});
        check_output({tag, " rdata"}, {24'd0, done_rdata}, {24'd0, v.exp_rdata});
        check_output({tag, " d_released"}, {24'd0, d_probe}, 32'd0);
    endtask

    initial begin
        int   bad_idle;
        int   bad_after_reset;
        vec_t post_reset;

        // we io addr wdata resp wait_lo poke exp_done exp_strobe exp_err exp_rdata
        vecs[0] = '{1'b1, 1'b1, 16'h0010, 8'h21, 8'h00, 0,   -10, 8,  6,  1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 16'h0011, 8'hFF, 8'h21, 0,   -10, 8,  6,  1'b0, 8'h21};
        vecs[2] = '{1'b0, 1'b0, 16'h4001, 8'hFF, 8'h5A, 0,   -10, 6,  4,  1'b0, 8'h5A};
        vecs[3] = '{1'b1, 1'b0, 16'h8123, 8'h3C, 8'h00, 3,   -10, 12, 10, 1'b0, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 16'h0200, 8'hFF, 8'h77, 255, -10, 34, 32, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 1'b1, 16'h00F8, 8'h96, 8'h00, 2,   -10, 12, 10, 1'b0, 8'h5A};
        vecs[6] = '{1'b0, 1'b1, 16'h00FF, 8'hFF, 8'h11, 255, -10, 36, 34, 1'b1, 8'h5A};
        vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 8'hFF, 8'hC3, 15,  -10, 36, 34, 1'b0, 8'hC3};
        vecs[8] = '{1'b0, 1'b1, 16'h0001, 8'hFF, 8'hE7, 15,  -10, 38, 36, 1'b0, 8'hE7};
        vecs[9] = '{1'b1, 1'b0, 16'hA55A, 8'h81, 8'h00, 1,   3,   8,  6,  1'b0, 8'hE7};

        bif.req   = 1'b0;
        bif.we    = 1'b0;
        bif.io    = 1'b0;
        bif.addr  = 16'h0000;
        bif.wdata = 8'h00;
        bif.WAIT  = 1'b1;
        resp_oe   = 1'b0;
        resp_val  = 8'h00;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset ready", {31'd0, bif.ready}, 32'd1);
        check_output("reset done", {31'd0, bif.done}, 32'd0);
        check_output("reset err", {31'd0, bif.err}, 32'd0);
        check_output("reset rdata", {24'd0, bif.rdata}, 32'd0);
        check_output("reset A", {16'd0, bif.A}, 32'd0);
        check_output("reset strobes", {27'd0, bif.MREQ, bif.IORQ, bif.RD, bif.WR, bif.M1}, 32'h1F);
        resp_oe = 1'b1;
        #1;
        check_output("reset d_released", {24'd0, d_bus}, 32'd0);
        resp_oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vectors run back to back: each request is raised in the previous done clock
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i], $sformatf("v%0d", i));
        end

        bad_idle = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (bif.ready !== 1'b1 || bif.MREQ !== 1'b1 || bif.IORQ !== 1'b1 || bif.done !== 1'b0) bad_idle++;
        end
        check_output("busy_req_not_queued", bad_idle, 0);

        // Asynchronous reset in the middle of a memory write
        bif.we    = 1'b1;
        bif.io    = 1'b0;
        bif.addr  = 16'h2222;
        bif.wdata = 8'h5A;
        bif.req   = 1'b1;
        @(negedge clk);
        bif.req = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midcycle MREQ", {31'd0, bif.MREQ}, 32'd0);
        check_output("midcycle WR", {31'd0, bif.WR}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_output("async MREQ", {31'd0, bif.MREQ}, 32'd1);
        check_output("async WR", {31'd0, bif.WR}, 32'd1);
        check_output("async ready", {31'd0, bif.ready}, 32'd1);
        check_output("async A", {16'd0, bif.A}, 32'd0);
        check_output("async rdata", {24'd0, bif.rdata}, 32'd0);
        resp_oe = 1'b1;
        #1;
        check_output("async d_released", {24'd0, d_bus}, 32'd0);
        resp_oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad_after_reset = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bif.done !== 1'b0 || bif.MREQ !== 1'b1 || bif.WR !== 1'b1 || bif.ready !== 1'b1) bad_after_reset++;
        end
        check_output("no_done_after_abort_reset", bad_after_reset, 0);

        post_reset = '{1'b0, 1'b0, 16'h1357, 8'hFF, 8'h3E, 0, -10, 6, 4, 1'b0, 8'h3E};
        apply_stimulus(post_reset, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
